// File: rtl/fb_port_arbiter_pkg.sv
// Shared display constants and types for the frame-buffer port arbiter.
package fb_port_arbiter_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_ADDR_W = 17;
  localparam int RGB_W     = 12;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_FILL = 1'b1
  } clr_state_e;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [RGB_W-1:0]     data;
  } wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Write queue between the renderer and the frame-buffer port.
// Circular buffer with count-based full/empty; pushes are refused when full.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 29
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + AW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    // Push and pop together leave the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads win, then the clear engine,
// then queued renderer writes. Clear state and queue depth are exposed for debug.
module fb_port_arbiter
  import fb_port_arbiter_pkg::*;
#(
  parameter int FB_PIXELS  = 76800,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        disp_req,
  input  logic [FB_ADDR_W-1:0]        disp_addr,
  output logic [RGB_W-1:0]            disp_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [FB_ADDR_W-1:0]        wr_addr,
  input  logic [RGB_W-1:0]            wr_data,
  input  logic                        clr_start,
  input  logic [RGB_W-1:0]            clr_color,
  output logic                        clr_busy,
  output logic                        clr_done,
  output logic [FB_ADDR_W-1:0]        mem_addr,
  output logic                        mem_we,
  output logic [RGB_W-1:0]            mem_wdata,
  input  logic [RGB_W-1:0]            mem_rdata,
  output clr_state_e                  dbg_clr_state,
  output logic [$clog2(FIFO_DEPTH):0] dbg_wq_count
);

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_PIXELS - 1);

  // Handshake: a write is taken on a clk edge where wr_valid && wr_ready;
  // wr_ready depends only on queue occupancy (never on a same-cycle pop).
  clr_state_e           state_q, state_d;
  logic [FB_ADDR_W-1:0] cnt_q, cnt_d;
  logic [RGB_W-1:0]     color_q, color_d;
  logic                 done_q, done_d;

  wr_entry_t            wq_head;
  wr_entry_t            wq_in;
  logic                 wq_full, wq_empty, wq_pop, wq_push;

  assign wr_ready      = reset_n && !wq_full;
  assign wq_push       = wr_valid && wr_ready;
  assign wq_in         = '{addr: wr_addr, data: wr_data};
  assign disp_data     = mem_rdata;
  assign clr_busy      = (state_q == CLR_FILL);
  assign clr_done      = done_q;
  assign dbg_clr_state = state_q;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wr_entry_t))
  ) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wq_push),
    .push_data (wq_in),
    .pop       (wq_pop),
    .head_data (wq_head),
    .count     (dbg_wq_count),
    .full      (wq_full),
    .empty     (wq_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    done_d  = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          state_d = CLR_FILL;
          cnt_d   = '0;
          color_d = clr_color;
        end
      end
      CLR_FILL: begin
        // Display cycles stall the fill; clr_start is ignored here.
        if (!disp_req) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = CLR_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + FB_ADDR_W'(1);
          end
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    wq_pop    = 1'b0;
    if (disp_req) begin
      mem_addr = disp_addr;
    end else if (state_q == CLR_FILL) begin
      mem_addr  = cnt_q;
      mem_we    = 1'b1;
      mem_wdata = color_q;
    end else if (!wq_empty) begin
      mem_addr  = wq_head.addr;
      mem_we    = 1'b1;
      mem_wdata = wq_head.data;
      wq_pop    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end

endmodule
